set_bit_iterator: RTL and testbench

- Sequential consumer of bit masks in the ALU/execute area; the scanning counterpart of the leading/trailing zero counter.
- Accepts a WIDTH-bit mask on a valid/ready input port.
- Emits the index of each set bit, one per cycle, in LSB-first or MSB-first order.
- Each beat carries the length of the zero run skipped to reach it. Used for register-list expansion (multi-register load/store sequencing) and bitmap walks.

---
 rtl/alu_pkg.sv | 17 +
 rtl/bit_scan_enc.sv | 30 +++
 rtl/set_bit_iterator.sv | 122 ++++++++++++
 tb/tb_set_bit_iterator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-area bit-mask utilities.
// Holds the scan-direction and iterator state encodings plus the default mask width.
package alu_pkg;

  typedef enum logic {
    SCAN_LSB = 1'b0,
    SCAN_MSB = 1'b1
  } scan_dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/bit_scan_enc.sv
// Combinational priority encoder: index of the lowest or highest set bit plus an any-set flag.
// Returns index 0 when no bit is set.
module bit_scan_enc
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_msbFirst,
  output logic [IDXW-1:0]  o_index,
  output logic             o_any
);

  // Each loop lets the last matching bit win, so the loop order picks the priority end.
  always_comb begin
    o_index = '0;
    o_any   = |i_mask;
    if (i_msbFirst) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_mask[i]) o_index = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_mask[i]) o_index = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/set_bit_iterator.sv
// Walks a mask and emits one beat per set bit (LSB- or MSB-first) with the zero run skipped.
// An all-zero mask yields a single empty beat; flush aborts the walk at any time.
module set_bit_iterator
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int GAPW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_index,
  output logic [GAPW-1:0]  out_gap,
  output logic             out_last,
  output logic             out_empty
);

  // One extra bit so prev can hold both -1 and WIDTH as two's-complement values.
  localparam int PW = GAPW + 1;

  state_e           r_state;
  state_e           w_stateNext;
  logic [WIDTH-1:0] r_mask;
  scan_dir_e        r_dir;
  logic [PW-1:0]    r_prev;

  logic [IDXW-1:0]  w_index;
  logic             w_any;
  logic             w_single;
  logic             w_emit;
  logic             w_accept;
  logic             w_handshake;
  logic [PW-1:0]    w_idxExt;
  logic [GAPW-1:0]  w_gapLsb;
  logic [GAPW-1:0]  w_gapMsb;

  bit_scan_enc #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_scan (
    .i_mask     (r_mask),
    .i_msbFirst (r_dir == SCAN_MSB),
    .o_index    (w_index),
    .o_any      (w_any)
  );

  assign w_emit      = (r_state == ST_EMIT);
  assign w_accept    = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_handshake = w_emit && out_ready && !flush;
  assign w_single    = ((r_mask & (r_mask - WIDTH'(1))) == '0);
  assign w_idxExt    = PW'(w_index);
  assign w_gapLsb    = GAPW'(w_idxExt - r_prev - PW'(1));
  assign w_gapMsb    = GAPW'(r_prev - PW'(1) - w_idxExt);

  always_comb begin
    w_stateNext = r_state;
    if (flush) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) w_stateNext = ST_EMIT;
        ST_EMIT: if (out_ready && out_last) w_stateNext = ST_IDLE;
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Outputs come only from registered state, so they hold steady under backpressure.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = w_emit;
    out_index = '0;
    out_gap   = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    if (w_emit) begin
      out_index = w_index;
      out_empty = !w_any;
      out_last  = !w_any || w_single;
      if (!w_any)                out_gap = GAPW'(WIDTH);
      else if (r_dir == SCAN_MSB) out_gap = w_gapMsb;
      else                        out_gap = w_gapLsb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // prev starts just outside the scan edge so the first gap counts from that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_dir  <= SCAN_LSB;
      r_prev <= '1;
    end else if (flush) begin
      r_mask <= '0;
      r_prev <= '1;
    end else if (w_accept) begin
      r_mask <= in_mask;
      r_dir  <= in_msb_first ? SCAN_MSB : SCAN_LSB;
      r_prev <= in_msb_first ? PW'(WIDTH) : '1;
    end else if (w_handshake) begin
      if (out_last) begin
        r_mask <= '0;
        r_prev <= '1;
      end else begin
        r_mask <= r_mask & ~(WIDTH'(1) << w_index);
        r_prev <= w_idxExt;
      end
    end
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Self-checking bench for set_bit_iterator: directed plan cases plus random masks
// checked against a loop-based reference model of the expected beat sequence.
module tb_set_bit_iterator;

  localparam int WIDTH = 32;
  localparam int IDXW  = 5;
  localparam int GAPW  = 6;

  typedef struct {
    int idx;
    int gap;
    bit last;
    bit empty;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic [GAPW-1:0]  out_gap;
  logic             out_last;
  logic             out_empty;

  int    testCount = 0;
  int    failCount = 0;
  beat_t expQ[$];

  set_bit_iterator #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW),
    .GAPW  (GAPW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mask      (in_mask),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_gap      (out_gap),
    .out_last     (out_last),
    .out_empty    (out_empty)
  );

  always #5 clk = ~clk;

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd1);
    checkOutput({tag, "_out_index"}, 64'(out_index), 64'd0);
    checkOutput({tag, "_out_gap"},   64'(out_gap),   64'd0);
    checkOutput({tag, "_out_last"},  64'(out_last),  64'd0);
    checkOutput({tag, "_out_empty"}, 64'(out_empty), 64'd0);
  endtask

  // Reference: walk the mask in scan order, measuring each zero run from the edge or previous hit.
  task automatic buildModel(input logic [WIDTH-1:0] mask, input bit msbFirst);
    int    prevPos;
    beat_t b;
    expQ.delete();
    prevPos = msbFirst ? WIDTH : -1;
    for (int k = 0; k < WIDTH; k++) begin
      int pos;
      pos = msbFirst ? (WIDTH - 1 - k) : k;
      if (mask[pos]) begin
        b.idx   = pos;
        b.gap   = msbFirst ? (prevPos - pos - 1) : (pos - prevPos - 1);
        b.last  = 1'b0;
        b.empty = 1'b0;
        expQ.push_back(b);
        prevPos = pos;
      end
    end
    if (expQ.size() == 0) begin
      b.idx = 0; b.gap = WIDTH; b.last = 1'b1; b.empty = 1'b1;
      expQ.push_back(b);
    end else begin
      expQ[expQ.size() - 1].last = 1'b1;
    end
  endtask

  task automatic acceptMask(input logic [WIDTH-1:0] mask, input bit msbFirst);
    checkOutput("accept_in_ready", 64'(in_ready), 64'd1);
    in_valid     = 1'b1;
    in_mask      = mask;
    in_msb_first = msbFirst;
    stepClk();
    in_valid     = 1'b0;
    in_mask      = '0;
  endtask

  task automatic checkBeat(input string tag, input beat_t b);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd0);
    checkOutput({tag, "_out_index"}, 64'(out_index), 64'(b.idx));
    checkOutput({tag, "_out_gap"},   64'(out_gap),   64'(b.gap));
    checkOutput({tag, "_out_last"},  64'(out_last),  64'(b.last));
    checkOutput({tag, "_out_empty"}, 64'(out_empty), 64'(b.empty));
  endtask

  // Drains expQ against the DUT; each stalled cycle re-checks the same beat, proving stability.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] mask, input bit msbFirst, input bit randReady);
    int  cycles;
    bit  rdy;
    acceptMask(mask, msbFirst);
    cycles = 0;
    while (expQ.size() > 0 && cycles < 400) begin
      rdy       = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      checkBeat(tag, expQ[0]);
      stepClk();
      if (rdy) void'(expQ.pop_front());
      cycles++;
    end
    out_ready = 1'b1;
    checkOutput({tag, "_beats_left"}, 64'(expQ.size()), 64'd0);
    checkIdleOutputs({tag, "_done"});
  endtask

  initial begin
    beat_t b;
    rst_n        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_mask      = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b1;

    #12;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    stepClk();
    checkIdleOutputs("post_reset");

    // Sparse mask LSB-first with the literal plan beats.
    expQ.delete();
    b = '{0, 0, 1'b0, 1'b0};   expQ.push_back(b);
    b = '{4, 3, 1'b0, 1'b0};   expQ.push_back(b);
    b = '{31, 26, 1'b1, 1'b0}; expQ.push_back(b);
    applyStimulus("sparse_lsb", 32'h8000_0011, 1'b0, 1'b0);

    expQ.delete();
    b = '{31, 0, 1'b0, 1'b0};  expQ.push_back(b);
    b = '{4, 26, 1'b0, 1'b0};  expQ.push_back(b);
    b = '{0, 3, 1'b1, 1'b0};   expQ.push_back(b);
    applyStimulus("sparse_msb", 32'h8000_0011, 1'b1, 1'b0);

    expQ.delete();
    b = '{0, 32, 1'b1, 1'b1};  expQ.push_back(b);
    applyStimulus("empty", 32'h0, 1'b0, 1'b0);

    expQ.delete();
    b = '{31, 31, 1'b1, 1'b0}; expQ.push_back(b);
    applyStimulus("top_bit", 32'h8000_0000, 1'b0, 1'b0);

    buildModel(32'hFFFF_FFFF, 1'b0);
    applyStimulus("full_rand_ready", 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Flush after two accepted beats; the third beat's handshake must not complete.
    acceptMask(32'h0000_F000, 1'b0);
    out_ready = 1'b1;
    b = '{12, 12, 1'b0, 1'b0}; checkBeat("flush_b0", b); stepClk();
    b = '{13, 0, 1'b0, 1'b0};  checkBeat("flush_b1", b); stepClk();
    b = '{14, 0, 1'b0, 1'b0};  checkBeat("flush_b2", b);
    flush = 1'b1;
    stepClk();
    flush = 1'b0;
    checkIdleOutputs("after_flush");
    expQ.delete();
    b = '{0, 0, 1'b1, 1'b0};   expQ.push_back(b);
    applyStimulus("post_flush", 32'h1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream must take effect before any clock edge.
    acceptMask(32'h0000_F000, 1'b0);
    stepClk();
    stepClk();
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    #3;
    rst_n = 1'b1;
    stepClk();
    checkIdleOutputs("after_reset");
    expQ.delete();
    b = '{0, 0, 1'b1, 1'b0};   expQ.push_back(b);
    applyStimulus("post_reset_mask", 32'h1, 1'b0, 1'b0);

    // flush beats a simultaneous offer in IDLE.
    in_valid = 1'b1;
    in_mask  = 32'h0000_00FF;
    flush    = 1'b1;
    stepClk();
    in_valid = 1'b0;
    flush    = 1'b0;
    checkIdleOutputs("flush_vs_valid");
    stepClk();
    checkIdleOutputs("flush_vs_valid_2");

    for (int n = 0; n < 24; n++) begin
      logic [WIDTH-1:0] m;
      bit               dir;
      m = $urandom();
      if (n % 3 == 1) m = m & $urandom() & $urandom();
      if (n == 5) m = '0;
      dir = 1'($urandom_range(0, 1));
      buildModel(m, dir);
      applyStimulus("random", m, dir, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
